kbd_event_decoder: RTL and testbench

KBD_EVENT_DECODER -- requirements
Module: kbd_event_decoder

---
 rtl/kbd_pkg.sv | 21 ++
 rtl/kbd_fifo.sv | 49 ++++
 rtl/kbd_event_decoder.sv | 160 ++++++++++++++++
 tb/tb_kbd_event_decoder.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared types and scan-code constants for the PS/2 keyboard event decoder.
`timescale 1ns/1ps
package kbd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } kbd_state_t;

    localparam logic [7:0] CODE_BRK    = 8'hF0;
    localparam logic [7:0] CODE_EXT    = 8'hE0;
    localparam logic [7:0] CODE_LSHIFT = 8'h12;
    localparam logic [7:0] CODE_RSHIFT = 8'h59;
    localparam logic [7:0] CODE_CAPS   = 8'h58;
    localparam logic [7:0] CODE_SPACE  = 8'h29;
    localparam logic [7:0] CODE_ENTER  = 8'h5A;
    localparam logic [7:0] CODE_BKSP   = 8'h66;

endpackage

// File: rtl/kbd_fifo.sv
// Show-ahead synchronous FIFO; the read port keeps the last popped value while empty.
`timescale 1ns/1ps
module kbd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] last_q;
    logic             wr_en, rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en = pop && !empty;
    // A push into a full queue still fits when the head leaves in the same cycle.
    assign wr_en = push && (!full || rd_en);

    assign rd_data = empty ? last_q : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            last_q <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
                last_q <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/kbd_event_decoder.sv
// PS/2 set-2 scan byte decoder: prefix FSM, modifier tracking, ASCII mapping and output queue.
`timescale 1ns/1ps
module kbd_event_decoder
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int LOWER_EN   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       code_valid,
    input  logic [7:0] code,
    output logic       ascii_valid,
    input  logic       ascii_ready,
    output logic [7:0] ascii,
    output logic       shift,
    output logic       caps_lock,
    output logic       overflow,
    output logic [7:0] key_count
);
    // state      | meaning
    // ST_IDLE    | no prefix pending; next byte is a make or a prefix
    // ST_BRK     | 0xF0 seen; next byte is a break code
    // ST_EXT     | 0xE0 seen; extended make ignored unless 0xF0 follows
    // ST_EXT_BRK | 0xE0 0xF0 seen; next byte is an ignored extended break

    kbd_state_t state_q, state_d;
    logic       make_stb, brk_stb;
    logic       lshift_q, rshift_q, caps_held_q;
    logic [8:0] map;
    logic       push, pop, push_ok, full, empty;

    function automatic logic [8:0] scan_to_ascii(input logic [7:0] sc, input logic shf,
                                                 input logic caps);
        logic [7:0] ch;
        logic       is_letter;
        logic       ok;
        ch        = 8'h00;
        is_letter = 1'b0;
        ok        = 1'b1;
        case (sc)
            8'h1C: begin ch = 8'h41; is_letter = 1'b1; end
            8'h32: begin ch = 8'h42; is_letter = 1'b1; end
            8'h21: begin ch = 8'h43; is_letter = 1'b1; end
            8'h23: begin ch = 8'h44; is_letter = 1'b1; end
            8'h24: begin ch = 8'h45; is_letter = 1'b1; end
            8'h2B: begin ch = 8'h46; is_letter = 1'b1; end
            8'h34: begin ch = 8'h47; is_letter = 1'b1; end
            8'h33: begin ch = 8'h48; is_letter = 1'b1; end
            8'h43: begin ch = 8'h49; is_letter = 1'b1; end
            8'h3B: begin ch = 8'h4A; is_letter = 1'b1; end
            8'h42: begin ch = 8'h4B; is_letter = 1'b1; end
            8'h4B: begin ch = 8'h4C; is_letter = 1'b1; end
            8'h3A: begin ch = 8'h4D; is_letter = 1'b1; end
            8'h31: begin ch = 8'h4E; is_letter = 1'b1; end
            8'h44: begin ch = 8'h4F; is_letter = 1'b1; end
            8'h4D: begin ch = 8'h50; is_letter = 1'b1; end
            8'h15: begin ch = 8'h51; is_letter = 1'b1; end
            8'h2D: begin ch = 8'h52; is_letter = 1'b1; end
            8'h1B: begin ch = 8'h53; is_letter = 1'b1; end
            8'h2C: begin ch = 8'h54; is_letter = 1'b1; end
            8'h3C: begin ch = 8'h55; is_letter = 1'b1; end
            8'h2A: begin ch = 8'h56; is_letter = 1'b1; end
            8'h1D: begin ch = 8'h57; is_letter = 1'b1; end
            8'h22: begin ch = 8'h58; is_letter = 1'b1; end
            8'h35: begin ch = 8'h59; is_letter = 1'b1; end
            8'h1A: begin ch = 8'h5A; is_letter = 1'b1; end
            8'h45: ch = shf ? 8'h29 : 8'h30;
            8'h16: ch = shf ? 8'h21 : 8'h31;
            8'h1E: ch = shf ? 8'h40 : 8'h32;
            8'h26: ch = shf ? 8'h23 : 8'h33;
            8'h25: ch = shf ? 8'h24 : 8'h34;
            8'h2E: ch = shf ? 8'h25 : 8'h35;
            8'h36: ch = shf ? 8'h5E : 8'h36;
            8'h3D: ch = shf ? 8'h26 : 8'h37;
            8'h3E: ch = shf ? 8'h2A : 8'h38;
            8'h46: ch = shf ? 8'h28 : 8'h39;
            CODE_SPACE: ch = 8'h20;
            CODE_ENTER: ch = 8'h0D;
            CODE_BKSP:  ch = 8'h08;
            default:    ok = 1'b0;
        endcase
        if (is_letter && (LOWER_EN != 0) && !(shf ^ caps)) ch = ch | 8'h20;
        return {ok, ch};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        make_stb = 1'b0;
        brk_stb  = 1'b0;
        if (code_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (code == CODE_BRK)      state_d = ST_BRK;
                    else if (code == CODE_EXT) state_d = ST_EXT;
                    else                       make_stb = 1'b1;
                end
                ST_EXT:  state_d = (code == CODE_BRK) ? ST_EXT_BRK : ST_IDLE;
                ST_BRK: begin
                    brk_stb = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign shift   = lshift_q | rshift_q;
    assign map     = scan_to_ascii(code, shift, caps_lock);
    assign push    = make_stb && map[8];
    assign pop     = ascii_valid && ascii_ready;
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            caps_lock   <= 1'b0;
            caps_held_q <= 1'b0;
            overflow    <= 1'b0;
            key_count   <= 8'd0;
        end else begin
            if (make_stb) begin
                if (code == CODE_LSHIFT) lshift_q <= 1'b1;
                if (code == CODE_RSHIFT) rshift_q <= 1'b1;
                // Typematic repeats of caps lock arrive with caps_held set and must not re-toggle.
                if (code == CODE_CAPS) begin
                    if (!caps_held_q) caps_lock <= ~caps_lock;
                    caps_held_q <= 1'b1;
                end
            end
            if (brk_stb) begin
                if (code == CODE_LSHIFT) lshift_q    <= 1'b0;
                if (code == CODE_RSHIFT) rshift_q    <= 1'b0;
                if (code == CODE_CAPS)   caps_held_q <= 1'b0;
            end
            if (push && !push_ok) overflow  <= 1'b1;
            if (push_ok)          key_count <= key_count + 8'd1;
        end
    end

    kbd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (map[7:0]),
        .pop     (pop),
        .rd_data (ascii),
        .full    (full),
        .empty   (empty)
    );

    assign ascii_valid = !empty;

endmodule

// File: tb/tb_kbd_event_decoder.sv
// Directed bench for kbd_event_decoder with hand-computed expected characters.
`timescale 1ns/1ps
module tb_kbd_event_decoder;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       code_valid;
    logic [7:0] code;
    logic       ascii_valid;
    logic       ascii_ready;
    logic [7:0] ascii;
    logic       shift;
    logic       caps_lock;
    logic       overflow;
    logic [7:0] key_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    kbd_event_decoder #(.FIFO_DEPTH(8), .LOWER_EN(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .code_valid  (code_valid),
        .code        (code),
        .ascii_valid (ascii_valid),
        .ascii_ready (ascii_ready),
        .ascii       (ascii),
        .shift       (shift),
        .caps_lock   (caps_lock),
        .overflow    (overflow),
        .key_count   (key_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge after the byte was taken.
    task automatic send(input logic [7:0] b);
        code       = b;
        code_valid = 1'b1;
        @(negedge clk);
        code_valid = 1'b0;
    endtask

    task automatic pop_one();
        ascii_ready = 1'b1;
        @(negedge clk);
        ascii_ready = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_valid"},    ascii_valid, 0);
        chk({tag, "_ascii"},    ascii,       8'h00);
        chk({tag, "_shift"},    shift,       0);
        chk({tag, "_caps"},     caps_lock,   0);
        chk({tag, "_overflow"}, overflow,    0);
        chk({tag, "_keycnt"},   key_count,   8'd0);
    endtask

    initial begin
        logic [7:0] fill_codes [9];
        fill_codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};

        rst_n       = 1'b0;
        code_valid  = 1'b0;
        code        = 8'h00;
        ascii_ready = 1'b0;
        #3;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Lower-case letter, latency, break ignored, empty-pop holds last value
        chk("t1_pre_valid", ascii_valid, 0);
        send(8'h1C);
        chk("t1_valid_n1", ascii_valid, 1);
        chk("t1_ascii", ascii, 8'h61);
        send(8'hF0);
        send(8'h1C);
        chk("t1_keycnt", key_count, 8'd1);
        pop_one();
        chk("t1_empty", ascii_valid, 0);
        chk("t1_hold", ascii, 8'h61);
        pop_one();
        chk("t1_underflow", ascii_valid, 0);

        // Shift sequence, shifted digit, specials, unmapped
        send(8'h12);
        chk("t2_shift_on", shift, 1);
        send(8'h1C);
        send(8'hF0); send(8'h1C);
        send(8'hF0); send(8'h12);
        send(8'h16);
        chk("t2_shift_off", shift, 0);
        send(8'h59);
        send(8'h16);
        send(8'hF0); send(8'h59);
        send(8'h29); send(8'h5A); send(8'h66); send(8'h76);
        chk("t2_keycnt", key_count, 8'd7);
        chk("t2_d0", ascii, 8'h41); pop_one();
        chk("t2_d1", ascii, 8'h31); pop_one();
        chk("t2_d2", ascii, 8'h21); pop_one();
        chk("t2_d3", ascii, 8'h20); pop_one();
        chk("t2_d4", ascii, 8'h0D); pop_one();
        chk("t2_d5", ascii, 8'h08); pop_one();
        chk("t2_empty", ascii_valid, 0);

        // Caps lock with typematic repeat
        send(8'h58); send(8'h58); send(8'hF0); send(8'h58);
        chk("t3_caps_on", caps_lock, 1);
        send(8'h1C);
        send(8'h12); send(8'h1C); send(8'hF0); send(8'h12);
        send(8'h16);
        chk("t3_keycnt", key_count, 8'd10);
        chk("t3_d0", ascii, 8'h41); pop_one();
        chk("t3_d1", ascii, 8'h61); pop_one();
        chk("t3_d2", ascii, 8'h31); pop_one();
        send(8'h58); send(8'hF0); send(8'h58);
        chk("t3_caps_off", caps_lock, 0);

        // Overflow with nine makes, order preserved on drain
        chk("t4_ovf_pre", overflow, 0);
        for (int i = 0; i < 9; i++) send(fill_codes[i]);
        chk("t4_overflow", overflow, 1);
        chk("t4_keycnt", key_count, 8'd18);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t4_drain%0d", i), ascii, 32'h61 + i);
            pop_one();
        end
        chk("t4_empty", ascii_valid, 0);

        // Full queue with simultaneous push and pop
        for (int i = 0; i < 8; i++) send(8'h1C);
        chk("t5_keycnt_full", key_count, 8'd26);
        code        = 8'h32;
        code_valid  = 1'b1;
        ascii_ready = 1'b1;
        @(negedge clk);
        code_valid  = 1'b0;
        ascii_ready = 1'b0;
        chk("t5_keycnt_pp", key_count, 8'd27);
        for (int i = 0; i < 7; i++) pop_one();
        chk("t5_last", ascii, 8'h62);
        chk("t5_last_valid", ascii_valid, 1);
        pop_one();
        chk("t5_empty", ascii_valid, 0);

        // Extended codes ignored
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("t6_none", ascii_valid, 0);
        send(8'h1C);
        chk("t6_ascii", ascii, 8'h61);
        chk("t6_keycnt", key_count, 8'd28);

        // Reset after a pending break prefix
        send(8'h12);
        send(8'hF0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("t7_rst");
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h1C);
        chk("t7_valid", ascii_valid, 1);
        chk("t7_ascii", ascii, 8'h61);
        chk("t7_keycnt", key_count, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
